execute_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit beside the single-cycle execute stage.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/muldiv_iter_core.sv | 55 +++++
 rtl/execute_muldiv.sv | 178 +++++++++++++++++
 tb/tb_execute_muldiv.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 types for the execute stage: multiply/divide op codes and unit states.
package riscv_pkg;

  typedef enum logic [2:0] {
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE, MD_CALC, MD_DONE
  } muldiv_state_e;

  // DIV/DIVU/REM/REMU occupy the upper half of the encoding.
  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 datapath: shift-add multiply or restoring divide on a 2*XLEN shift register.
module muldiv_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              div_i,
  input  logic              step_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_next_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              div_q;

  logic [XLEN-1:0] hi, lo;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] rem_diff;

  always_comb begin
    hi       = acc_q[2*XLEN-1:XLEN];
    lo       = acc_q[XLEN-1:0];
    // Multiply: low half holds the multiplier, product shifts in from the top.
    mul_sum  = lo[0] ? ({1'b0, hi} + {1'b0, opnd_q}) : {1'b0, hi};
    // Divide: low half holds the dividend, quotient bits shift in from the bottom.
    rem_sh   = {hi, lo[XLEN-1]};
    rem_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    if (!div_q) begin
      acc_next_o = {mul_sum, lo[XLEN-1:1]};
    end else if (rem_diff[XLEN+1]) begin
      acc_next_o = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    end else begin
      acc_next_o = {rem_diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      acc_q  <= {{XLEN{1'b0}}, (div_i ? a_i : b_i)};
      opnd_q <= div_i ? b_i : a_i;
      div_q  <= div_i;
    end else if (step_i) begin
      acc_q  <= acc_next_o;
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier on the MUL ops.
module execute_muldiv
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [XLEN-1:0]  req_rs1_i,
  input  logic [XLEN-1:0]  req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  muldiv_op_e      op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic            neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] data_q, data_d;

  muldiv_op_e      req_op;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special, handshake, core_load;
  logic [XLEN-1:0] special_data;
  logic            fast_mul;
  logic [XLEN-1:0] fast_data;

  logic [2*XLEN-1:0] acc_next, prod_fix;
  logic [XLEN-1:0]   quot, rem, calc_data;

  always_comb begin
    req_op   = muldiv_op_e'(req_op_i);
    a_signed = (req_op == MULH) || (req_op == MULHSU) || (req_op == DIV) || (req_op == REM);
    b_signed = (req_op == MULH) || (req_op == DIV) || (req_op == REM);
    a_neg    = a_signed & req_rs1_i[XLEN-1];
    b_neg    = b_signed & req_rs2_i[XLEN-1];
    a_mag    = a_neg ? -req_rs1_i : req_rs1_i;
    b_mag    = b_neg ? -req_rs2_i : req_rs2_i;
    div_zero = is_div(req_op) && (req_rs2_i == '0);
    div_ovf  = ((req_op == DIV) || (req_op == REM)) && (req_rs1_i == MinVal) && (&req_rs2_i);
    special  = div_zero | div_ovf;
    if (div_zero) begin
      special_data = ((req_op == DIV) || (req_op == DIVU)) ? '1 : req_rs1_i;
    end else begin
      special_data = (req_op == DIV) ? req_rs1_i : '0;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  always_comb begin
    fast_a    = {{XLEN{a_neg}}, req_rs1_i};
    fast_b    = {{XLEN{b_neg}}, req_rs2_i};
    fast_prod = fast_a * fast_b;
    fast_mul  = !is_div(req_op);
    fast_data = (req_op == MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  assign fast_mul  = 1'b0;
  assign fast_data = '0;
`endif

  assign handshake = req_valid_i & (state_q == MD_IDLE) & ~flush_i;
  assign core_load = handshake & ~special & ~fast_mul;

  muldiv_iter_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (core_load),
    .div_i     (is_div(req_op)),
    .step_i    (state_q == MD_CALC),
    .a_i       (a_mag),
    .b_i       (b_mag),
    .acc_next_o(acc_next)
  );

  // Sign fix-up applied to the final step's value so DONE holds the finished result.
  always_comb begin
    prod_fix = neg_res_q ? -acc_next : acc_next;
    quot     = acc_next[XLEN-1:0];
    rem      = acc_next[2*XLEN-1:XLEN];
    unique case (op_q)
      MUL:               calc_data = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: calc_data = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:         calc_data = neg_res_q ? -quot : quot;
      default:           calc_data = neg_rem_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    data_d    = data_q;
    unique case (state_q)
      MD_IDLE: begin
        if (handshake) begin
          op_d      = req_op;
          tag_d     = req_tag_i;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (special) begin
            data_d  = special_data;
            state_d = MD_DONE;
          end else if (fast_mul) begin
            data_d  = fast_data;
            state_d = MD_DONE;
          end else begin
            cnt_d   = CntW'(XLEN);
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          data_d  = calc_data;
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        if (resp_ready_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      op_q      <= MUL;
      tag_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      data_q    <= data_d;
    end
  end

  assign req_ready_o  = (state_q == MD_IDLE);
  assign resp_valid_o = (state_q == MD_DONE);
  assign busy_o       = (state_q != MD_IDLE);
  assign resp_data_o  = data_q;
  assign resp_tag_o   = tag_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed-vector bench for execute_muldiv (XLEN=32) with hand-computed results.
module tb_execute_muldiv;
  import riscv_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = XLEN + 1;
`endif
  localparam int DivLat = XLEN + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [2:0]       req_op_i;
  logic [XLEN-1:0]  req_rs1_i;
  logic [XLEN-1:0]  req_rs2_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [XLEN-1:0]  resp_data_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic             busy_o;

  int checks   = 0;
  int failures = 0;

  execute_muldiv #(
    .XLEN (XLEN),
    .TAG_W(TAG_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_rs1_i   (req_rs1_i),
    .req_rs2_i   (req_rs2_i),
    .req_tag_i   (req_tag_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_data_o (resp_data_o),
    .resp_tag_o  (resp_tag_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_rs1_i   = a;
    req_rs2_i   = b;
    req_tag_i   = t;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Latency counts the handshake edge as 1; bounded so a dead unit cannot hang the run.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid_o && lat < 100) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  task automatic retire();
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic run(input string tag, input muldiv_op_e op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp,
                     input int exp_lat);
    int lat;
    issue(op, a, b, t);
    wait_resp(lat);
    check_eq({tag, " data"}, resp_data_o, exp);
    check_eq({tag, " tag"}, 32'(resp_tag_o), 32'(t));
    check_eq({tag, " latency"}, lat, exp_lat);
    retire();
  endtask

  initial begin
    int lat;
    int seen;
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    req_valid_i  = 1'b0;
    req_op_i     = 3'd0;
    req_rs1_i    = '0;
    req_rs2_i    = '0;
    req_tag_i    = '0;
    resp_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst ready", req_ready_o, 1);
    check_eq("rst valid", resp_valid_o, 0);
    check_eq("rst busy", busy_o, 0);
    check_eq("rst data", resp_data_o, 0);
    check_eq("rst tag", 32'(resp_tag_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    run("mul neg", MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, MulLat);
    run("mul pos", MUL, 32'h1234_5678, 32'h10, 5'd2, 32'h2345_6780, MulLat);
    run("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, MulLat);
    run("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, MulLat);
    run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, MulLat);

    run("div neg", DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, DivLat);
    run("rem neg", REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, DivLat);
    run("divu", DIVU, 32'd100, 32'd7, 5'd10, 32'd14, DivLat);
    run("remu", REMU, 32'd100, 32'd7, 5'd11, 32'd2, DivLat);
    run("div negdivisor", DIV, 32'd100, 32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF2, DivLat);
    run("rem negdivisor", REM, 32'd100, 32'hFFFF_FFF9, 5'd13, 32'd2, DivLat);

    run("divu by0", DIVU, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
    run("remu by0", REMU, 32'd5, 32'd0, 5'd15, 32'd5, 1);
    run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1);

    // Backpressure: result must hold for 10 stalled cycles.
    issue(DIVU, 32'd100, 32'd7, 5'd20);
    wait_resp(lat);
    check_eq("bp first valid", resp_valid_o, 1);
    seen = 0;
    repeat (10) begin
      @(posedge clk_i);
      #1;
      if (resp_valid_o !== 1'b1 || resp_data_o !== 32'd14 || resp_tag_o !== 5'd20 ||
          req_ready_o !== 1'b0) seen++;
    end
    check_eq("bp stall unstable cycles", seen, 0);
    retire();
    check_eq("bp ready after retire", req_ready_o, 1);
    check_eq("bp valid after retire", resp_valid_o, 0);

    run("b2b first", MUL, 32'd3, 32'd5, 5'd3, 32'd15, MulLat);
    run("b2b second", DIVU, 32'd81, 32'd9, 5'd9, 32'd9, DivLat);

    // Flush at CALC cycle 5 kills the op for good.
    issue(DIVU, 32'd1000, 32'd3, 5'd21);
    repeat (4) begin
      @(posedge clk_i);
      #1;
    end
    check_eq("flush busy before", busy_o, 1);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    check_eq("flush busy", busy_o, 0);
    check_eq("flush ready", req_ready_o, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk_i);
      #1;
      if (resp_valid_o) seen++;
    end
    check_eq("flush no resp", seen, 0);

    // Flush wins over a same-cycle request.
    req_valid_i = 1'b1;
    req_op_i    = DIVU;
    req_rs1_i   = 32'd9;
    req_rs2_i   = 32'd0;
    flush_i     = 1'b1;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    check_eq("flush drops req busy", busy_o, 0);
    check_eq("flush drops req valid", resp_valid_o, 0);

    // Asynchronous reset mid-CALC, asserted away from any clock edge.
    issue(DIVU, 32'd1000, 32'd3, 5'd22);
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    #3;
    rst_i = 1'b1;
    #1;
    check_eq("async rst busy", busy_o, 0);
    check_eq("async rst valid", resp_valid_o, 0);
    check_eq("async rst ready", req_ready_o, 1);
    check_eq("async rst data", resp_data_o, 0);
    #2;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    run("post rst divu", DIVU, 32'd1000, 32'd3, 5'd23, 32'd333, DivLat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
